// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Sequential instruction fetch front end. After a start pulse the controller
// walks pc_o upward in 4-byte steps from RESET_PC, captures the instruction
// word returned combinationally by the instruction memory, and buffers
// {pc, instr} pairs in a 2-entry FIFO that the consumer drains through a
// valid/ready handshake. Fetching stops at the MEM_BYTES limit. The
// controller then drains the queue and halts. A redirect flushes the queue
// and restarts fetching at a new address. A misaligned redirect target flushes
// the queue, halts the controller and raises a sticky error.
//
// Parameters
//   RESET_PC        first fetch address after start
//   MEM_BYTES       instruction memory size in bytes (fetch limit)
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           synchronous, active-high reset
//   start           one-cycle pulse, honoured only in IDLE
//   pc_o            byte address driven to instruction memory
//   instr_i         instruction word for pc_o, same cycle
//   redirect_valid  redirect request (ignored in IDLE)
//   redirect_pc     redirect target byte address
//   out_valid       queue head holds a valid instruction
//   out_instr       queue head instruction
//   out_pc          byte address of out_instr
//   out_ready       consumer accepts the head when out_valid is high
//   busy            high in FETCH or DRAIN
//   halted          high in HALT
//   misalign_err    sticky, set by a misaligned redirect, cleared by reset
// -----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        busy,
    output logic        halted,
    output logic        misalign_err
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  count;        // occupancy of the 2-entry queue (0..2)
    logic [31:0] tail_pc;      // second queue entry; the head is out_pc/out_instr
    logic [31:0] tail_instr;

    // Handshake and control decode for the current cycle
    logic       pop;
    logic       push;
    logic       in_range;
    logic       redirect_take;
    logic       redirect_aligned;
    logic [1:0] count_next;

    assign out_valid = (count != 2'd0);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pop              = 1'b0;
        push             = 1'b0;
        in_range         = 1'b0;
        redirect_take    = 1'b0;
        redirect_aligned = 1'b0;
        count_next       = count;

        pop              = out_valid && out_ready;
        in_range         = (pc_o < MEM_LIMIT);
        redirect_take    = redirect_valid && (state != IDLE);
        redirect_aligned = (redirect_pc[1:0] == 2'b00);

        // A redirect suppresses the fetch in its own cycle. A push into a full
        // queue is allowed only when the head leaves on the same edge.
        push = (state == FETCH) && in_range && !redirect_take &&
               ((count != 2'd2) || pop);

        count_next = count + 2'(push) - 2'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement
    // order within the block.
    // NOTE: the queue storage is tiny and out_pc/out_instr must read zero after
    // reset, so the entries are reset along with the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc_o         <= RESET_PC;
            count        <= 2'd0;
            out_pc       <= 32'h0;
            out_instr    <= 32'h0;
            tail_pc      <= 32'h0;
            tail_instr   <= 32'h0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect_take) begin
            // Redirect wins over fetch, limit detection and DRAIN->HALT.
            // A head popped on this edge is consumed; everything else queued
            // is dropped by zeroing the occupancy.
            count <= 2'd0;
            if (redirect_aligned) begin
                pc_o   <= redirect_pc;
                state  <= FETCH;
                busy   <= 1'b1;
                halted <= 1'b0;
            end else begin
                misalign_err <= 1'b1;
                state        <= HALT;
                busy         <= 1'b0;
                halted       <= 1'b1;
            end
        end else begin
            // Queue data movement: a pop shifts the tail into the head, a push
            // lands in the first free slot after any pop.
            if (pop && push) begin
                if (count == 2'd2) begin
                    out_pc     <= tail_pc;
                    out_instr  <= tail_instr;
                    tail_pc    <= pc_o;
                    tail_instr <= instr_i;
                end else begin
                    out_pc    <= pc_o;
                    out_instr <= instr_i;
                end
            end else if (pop) begin
                if (count == 2'd2) begin
                    out_pc    <= tail_pc;
                    out_instr <= tail_instr;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    out_pc    <= pc_o;
                    out_instr <= instr_i;
                end else begin
                    tail_pc    <= pc_o;
                    tail_instr <= instr_i;
                end
            end

            count <= count_next;

            // pc_o advances only with a push, so it holds while the queue is
            // full and nothing is popped.
            if (push) begin
                pc_o <= pc_o + 32'd4;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        pc_o  <= RESET_PC;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!in_range) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_next == 2'd0) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    // Only a redirect or reset leaves HALT.
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//
// Directed bench for fetch_controller. Stimulus pushes the {pc, instr} pairs
// the consumer is expected to accept into a scoreboard queue; a monitor on the
// falling edge pops the queue on every handshake and compares it with the
// head that is being presented. Status outputs are checked directly from the
// stimulus thread one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        busy;
    logic        halted;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];   // {pc, instr} the consumer should accept, in order

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(112)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .busy          (busy),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_81B3;
        return 32'hA5A5_0000 ^ a;
    endfunction

    assign instr_i = imem(pc_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_range(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [31:0] a = lo; a <= hi; a += 32'd4) begin
            exp_q.push_back({a, imem(a)});
        end
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard monitor: a handshake on the coming edge consumes the head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc 0x%08h expected no entry", out_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("head_pc", out_pc, e[63:32]);
                check("head_instr", out_instr, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);

        // Full run with a consumer that is always ready
        out_ready = 1'b1;
        expect_range(32'h00, 32'h6C);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_valid_c1", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_valid_c2", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h0020_81B3);
        wait_halted("run_halted", 200);
        check("run_busy", 32'(busy), 32'd0);
        check("run_pc_end", pc_o, 32'h70);
        check("run_all_seen", 32'(exp_q.size()), 32'd0);

        // Backpressure: queue fills and pc_o holds
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        check("bp_pc_hold", pc_o, 32'h08);
        check("bp_head_pc", out_pc, 32'h00);
        check("bp_valid", 32'(out_valid), 32'd1);
        exp_q.push_back({32'h00, imem(32'h00)});
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("bp_head_after_pop", out_pc, 32'h04);
        check("bp_pc_after_pop", pc_o, 32'h0C);
        check("bp_all_seen", 32'(exp_q.size()), 32'd0);

        // Redirect with a full queue: stale entries are never presented
        do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick(1);
        redirect_valid = 1'b0;
        check("rd_flush_valid", 32'(out_valid), 32'd0);
        check("rd_pc", pc_o, 32'h40);
        expect_range(32'h40, 32'h6C);
        out_ready = 1'b1;
        wait_halted("rd_halted", 100);
        check("rd_all_seen", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect, then recovery with a valid redirect
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick(1);
        redirect_valid = 1'b0;
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_busy", 32'(busy), 32'd0);
        check("mis_valid", 32'(out_valid), 32'd0);
        check("mis_pc_hold", pc_o, 32'h04);
        tick(3);
        check("mis_stays_halted", 32'(halted), 32'd1);
        expect_range(32'h10, 32'h6C);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick(1);
        redirect_valid = 1'b0;
        check("rec_busy", 32'(busy), 32'd1);
        check("rec_halted", 32'(halted), 32'd0);
        check("rec_err_sticky", 32'(misalign_err), 32'd1);
        wait_halted("rec_halted_end", 100);
        check("rec_err_sticky_end", 32'(misalign_err), 32'd1);
        check("rec_all_seen", 32'(exp_q.size()), 32'd0);

        // Start ignored during FETCH; reset mid-fetch with full queue
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        tick(1);
        tick(1);   // start still high in FETCH
        start = 1'b0;
        check("start_ignored_pc", pc_o, 32'h04);
        tick(3);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_pc", pc_o, 32'h08);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_pc", pc_o, 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);

        // Redirect ignored in IDLE
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick(1);
        redirect_valid = 1'b0;
        check("idle_rd_pc", pc_o, 32'h00);
        check("idle_rd_busy", 32'(busy), 32'd0);

        // Refetch from HALT via redirect to 0
        out_ready = 1'b1;
        expect_range(32'h00, 32'h6C);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_halted("re_first_halt", 200);
        check("re_first_seen", 32'(exp_q.size()), 32'd0);
        expect_range(32'h00, 32'h6C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00;
        tick(1);
        redirect_valid = 1'b0;
        check("re_busy", 32'(busy), 32'd1);
        check("re_halted", 32'(halted), 32'd0);
        wait_halted("re_second_halt", 200);
        check("re_second_seen", 32'(exp_q.size()), 32'd0);
        check("re_final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
